mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access sequencer for the pipelined LC-3b core. Consumes the memory-related fields of the control word (produced in decode and carried through the EX/MEM latch) together with the EX-stage address and store data, and drives the data-cache port. Sequences the two-access LDI/STI indirection, performs byte-lane steering for LDB/STB, and holds the pipeline with a stall until the final cache response arrives.

## Interface
- No parameters; widths come from `lc3b_types` (`lc3b_word` = 16 bits).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  EX/MEM latch holds a valid instruction.
- `dcache_enable`, `dcacheR`, `dcacheW`, `ldi_op`, `sti_op`, `ldb_op`, `stb_op`  in  1 each  control-word fields.
- `addr`  in  16  effective address from EX.
- `store_data`  in  16  store source register value.
- `dmem_address`  out  16  cache address.
- `dmem_read`, `dmem_write`  out  1 each  cache strobes.
- `dmem_byte_enable`  out  2  byte lanes: bit 1 high byte, bit 0 low byte.
- `dmem_wdata`  out  16  cache write data.
- `dmem_rdata`  in  16  cache read data.
- `dmem_resp`  in  1  cache completion, one-cycle pulse.
- `load_data`  out  16  final load result to writeback; LDB zero-extended.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM latches.

## Operation
- States: `MS_FIRST` (idle or first access) and `MS_SECOND` (indirect second access). Register `ptr` (16 bits) holds the pointer fetched by LDI/STI.
- `MS_FIRST`, with `req_valid & dcache_enable`:
  - Drive `dmem_address = addr`, with bit 0 forced to 0 unless `ldb_op | stb_op`.
  - LDI or STI: the first access is always a read.
  - Otherwise `dmem_read = dcacheR` and `dmem_write = dcacheW`.
- On `dmem_resp` in `MS_FIRST`:
  - LDI/STI: latch `ptr <= dmem_rdata & 16'hFFFE`, go to `MS_SECOND`.
  - Otherwise the access is complete.
- `MS_SECOND`:
  - Drive `dmem_address = ptr`.
  - LDI: `dmem_read = 1`. STI: `dmem_write = 1`, `dmem_wdata = store_data`, `dmem_byte_enable = 2'b11`.
  - On `dmem_resp`: complete, return to `MS_FIRST`.
- Byte lanes:
  - Word access: `be = 2'b11`.
  - LDB/STB: `be = addr[0] ? 2'b10 : 2'b01`.
  - STB: `wdata = {store_data[7:0], store_data[7:0]}`.
  - LDB: `load_data = {8'h00, addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]}`.
  - Word loads: `load_data = dmem_rdata`.
- `mem_stall = req_valid & dcache_enable & ~final_resp`, where `final_resp = dmem_resp` in `MS_SECOND`, or in `MS_FIRST` for a non-indirect op. It is combinational.
- Non-memory instructions, or `req_valid = 0`: all strobes 0, `mem_stall = 0`, `dmem_byte_enable = 2'b00`.
- TRAP arrives as a plain word read (`dcacheR`) and needs no special handling.

## Timing
- Reset: state `MS_FIRST`, `ptr = 0`. With `req_valid = 0` this gives `dmem_read = dmem_write = 0`, `dmem_byte_enable = 0`, `mem_stall = 0`, and `dmem_address`, `dmem_wdata`, `load_data` = 0.
- Requests are Mealy outputs and are asserted in the same cycle the instruction reaches MEM.
- Requests hold stable until `dmem_resp`. Upstream guarantees stable inputs while `mem_stall = 1`.
- Plain access: stall lasts from entry until the resp cycle. The resp cycle itself has `mem_stall = 0` and valid `load_data`, and the next instruction enters on the following edge.
- LDI/STI: a minimum of 2 cycles; the second request begins on the cycle after the first resp.
- A zero-wait cache (`dmem_resp` in the request cycle) gives 1 cycle for plain ops and 2 for indirect ops.
- `dmem_resp` while no strobe is asserted is ignored; no state change.
- `rst` in `MS_SECOND` aborts the indirect op: strobes drop on the next cycle and the pointer clears.
- `ptr` updates only on the first-access resp of LDI/STI.

## Structure
- Add to `lc3b_types`: `typedef enum logic {MS_FIRST, MS_SECOND} lc3b_mem_state`.
- One combinational sub-module `mem_byte_lane`, containing byte-enable generation, STB data replication and LDB extraction.
- The FSM, `ptr` and stall logic stay in the top module.

## Test plan
- LDR word, `addr = 16'h3005`, resp after 3 cycles with `rdata = 16'hBEEF` -> `dmem_address = 16'h3004`, `be = 2'b11`, stall high for 3 cycles, `load_data = 16'hBEEF` on the resp cycle.
- LDB, `addr = 16'h2001`, `rdata = 16'hA57C` -> `be = 2'b10`, `load_data = 16'h00A5`. Same with `addr = 16'h2000` -> `be = 2'b01`, `load_data = 16'h007C`.
- STB, `addr = 16'h4000`, `store_data = 16'h1234` -> `dmem_write = 1`, `be = 2'b01`, `wdata = 16'h3434`.
- LDI, `addr = 16'h1000`, first `rdata = 16'h5003`, second `rdata = 16'h0042` -> second address `16'h5002`, stall across both accesses, `load_data = 16'h0042`.
- STI with zero-wait cache -> read cycle, then write of `store_data` at `ptr` with `be = 2'b11`, then stall drops on cycle 2. A spurious `dmem_resp` with no request leaves state unchanged.
- Assert `rst` while in `MS_SECOND` -> next cycle state `MS_FIRST`, `ptr = 0`, no strobes while `req_valid = 0`.

Source files
------------

// File: rtl/lc3b_types.sv
// ---------------------------------------------------------------------------
// lc3b_types
//   Shared types for the LC-3b pipeline memory stage.
//   - lc3b_word / lc3b_byte : datapath widths
//   - lc3b_mem_state        : memory-stage access sequencer states
//   - byte-enable encodings and a word-alignment helper
// ---------------------------------------------------------------------------
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [7:0]  lc3b_byte;

   typedef enum logic {
      MS_FIRST,
      MS_SECOND
   } lc3b_mem_state;

   localparam lc3b_word   WORD_ALIGN_MASK = 16'hFFFE;

   localparam logic [1:0] BE_NONE = 2'b00;
   localparam logic [1:0] BE_LOW  = 2'b01;
   localparam logic [1:0] BE_HIGH = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;

   // Word accesses ignore address bit 0; the cache always sees an even address.
   function automatic lc3b_word word_align(input lc3b_word a);
      return a & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// ---------------------------------------------------------------------------
// mem_byte_lane
//   Combinational byte-lane steering between the core and the data cache.
//   Ports:
//     i_ldb_op, i_stb_op : byte load / byte store of the current instruction
//     i_addr_lsb         : address bit 0, selects the high or low byte
//     i_store_data       : store source register value
//     i_rdata            : cache read data
//     o_be               : byte enables (bit 1 high byte, bit 0 low byte)
//     o_wdata            : cache write data (STB replicates the low byte)
//     o_load_data        : load result (LDB zero-extended)
// ---------------------------------------------------------------------------
module mem_byte_lane
   import lc3b_types::*;
(
   input  logic       i_ldb_op,
   input  logic       i_stb_op,
   input  logic       i_addr_lsb,
   input  lc3b_word   i_store_data,
   input  lc3b_word   i_rdata,
   output logic [1:0] o_be,
   output lc3b_word   o_wdata,
   output lc3b_word   o_load_data
);

   logic     w_byte_op;
   lc3b_byte w_rd_byte;

   assign w_byte_op = i_ldb_op | i_stb_op;
   assign w_rd_byte = i_addr_lsb ? i_rdata[15:8] : i_rdata[7:0];

   always_comb begin
      o_be        = BE_WORD;
      o_wdata     = i_store_data;
      o_load_data = i_rdata;

      if (w_byte_op) begin
         o_be = i_addr_lsb ? BE_HIGH : BE_LOW;
      end

      // The low byte is copied to both lanes so the enabled lane always
      // carries the store value regardless of address parity.
      if (i_stb_op) begin
         o_wdata = {i_store_data[7:0], i_store_data[7:0]};
      end

      if (i_ldb_op) begin
         o_load_data = {8'h00, w_rd_byte};
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Memory-stage access sequencer for the pipelined LC-3b core. Drives the
//   data-cache port from the EX/MEM control word, sequences the two-access
//   LDI/STI indirection and stalls the pipeline until the final response.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   MS_FIRST  | idle, plain access, or pointer read of LDI/STI
//   MS_SECOND | indirect data access at the latched pointer
//
//   Ports:
//     clk, rst                       : clock, synchronous active-high reset
//     req_valid                      : EX/MEM holds a valid instruction
//     dcache_enable, dcacheR/W       : control-word memory fields
//     ldi_op, sti_op, ldb_op, stb_op : instruction kind qualifiers
//     addr, store_data               : EX effective address, store source
//     dmem_*                         : data-cache request/response port
//     load_data                      : result to writeback
//     mem_stall                      : freeze upstream pipeline latches
// ---------------------------------------------------------------------------
module mem_access_unit
   import lc3b_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       dcache_enable,
   input  logic       dcacheR,
   input  logic       dcacheW,
   input  logic       ldi_op,
   input  logic       sti_op,
   input  logic       ldb_op,
   input  logic       stb_op,
   input  lc3b_word   addr,
   input  lc3b_word   store_data,
   output lc3b_word   dmem_address,
   output logic       dmem_read,
   output logic       dmem_write,
   output logic [1:0] dmem_byte_enable,
   output lc3b_word   dmem_wdata,
   input  lc3b_word   dmem_rdata,
   input  logic       dmem_resp,
   output lc3b_word   load_data,
   output logic       mem_stall
);

   lc3b_mem_state r_state;
   lc3b_mem_state w_next_state;
   lc3b_word      r_ptr;

   logic       w_active;
   logic       w_indirect;
   logic       w_byte_op;
   logic       w_final_resp;
   logic       w_ptr_load;
   logic [1:0] w_lane_be;
   lc3b_word   w_lane_wdata;
   lc3b_word   w_lane_load;

   assign w_active   = req_valid & dcache_enable;
   assign w_indirect = ldi_op | sti_op;
   assign w_byte_op  = ldb_op | stb_op;

   mem_byte_lane u_byte_lane (
      .i_ldb_op     (ldb_op),
      .i_stb_op     (stb_op),
      .i_addr_lsb   (addr[0]),
      .i_store_data (store_data),
      .i_rdata      (dmem_rdata),
      .o_be         (w_lane_be),
      .o_wdata      (w_lane_wdata),
      .o_load_data  (w_lane_load)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MS_FIRST;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_ptr_load) begin
         r_ptr <= word_align(dmem_rdata);
      end
   end

   always_comb begin
      w_next_state     = r_state;
      w_final_resp     = 1'b0;
      w_ptr_load       = 1'b0;
      dmem_address     = '0;
      dmem_read        = 1'b0;
      dmem_write       = 1'b0;
      dmem_byte_enable = BE_NONE;
      dmem_wdata       = '0;

      case (r_state)
         MS_FIRST: begin
            if (w_active) begin
               dmem_address = w_byte_op ? addr : word_align(addr);
               if (w_indirect) begin
                  // Pointer fetch: always a full-word read, whatever the
                  // control word says about the eventual data access.
                  dmem_read        = 1'b1;
                  dmem_byte_enable = BE_WORD;
                  if (dmem_resp) begin
                     w_ptr_load   = 1'b1;
                     w_next_state = MS_SECOND;
                  end
               end else begin
                  dmem_read        = dcacheR;
                  dmem_write       = dcacheW;
                  dmem_byte_enable = w_lane_be;
                  dmem_wdata       = w_lane_wdata;
                  // A response with no strobe up is not ours to consume.
                  if (dmem_resp && (dcacheR || dcacheW)) begin
                     w_final_resp = 1'b1;
                  end
               end
            end
         end

         MS_SECOND: begin
            if (w_active) begin
               dmem_address     = r_ptr;
               dmem_read        = ldi_op;
               dmem_write       = sti_op;
               dmem_byte_enable = BE_WORD;
               if (sti_op) begin
                  dmem_wdata = store_data;
               end
               if (dmem_resp && (ldi_op || sti_op)) begin
                  w_final_resp = 1'b1;
                  w_next_state = MS_FIRST;
               end
            end else begin
               // Instruction vanished mid-indirection; never leave a
               // stale second access pending for the next one.
               w_next_state = MS_FIRST;
            end
         end

         default: begin
            w_next_state = MS_FIRST;
         end
      endcase
   end

   assign mem_stall = w_active & ~w_final_resp;
   assign load_data = w_active ? w_lane_load : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        dcache_enable;
   logic        dcacheR;
   logic        dcacheW;
   logic        ldi_op;
   logic        sti_op;
   logic        ldb_op;
   logic        stb_op;
   logic [15:0] addr;
   logic [15:0] store_data;
   logic [15:0] dmem_address;
   logic        dmem_read;
   logic        dmem_write;
   logic [1:0]  dmem_byte_enable;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_resp;
   logic [15:0] load_data;
   logic        mem_stall;

   mem_access_unit dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .dcache_enable    (dcache_enable),
      .dcacheR          (dcacheR),
      .dcacheW          (dcacheW),
      .ldi_op           (ldi_op),
      .sti_op           (sti_op),
      .ldb_op           (ldb_op),
      .stb_op           (stb_op),
      .addr             (addr),
      .store_data       (store_data),
      .dmem_address     (dmem_address),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_byte_enable (dmem_byte_enable),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp),
      .load_data        (load_data),
      .mem_stall        (mem_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int K_LDR = 0, K_STR = 1, K_LDB = 2, K_STB = 3;
   localparam int K_LDI = 4, K_STI = 5, K_TRAP = 6, K_NOP = 7;

   typedef struct {
      logic [15:0] addr;
      logic        rd;
      logic        wr;
      logic [1:0]  be;
      logic [15:0] wdata;
      logic        stall;
      logic        chk_load;
      logic [15:0] load;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = 1'b0;
      dcache_enable = 1'b0;
      dcacheR       = 1'b0;
      dcacheW       = 1'b0;
      ldi_op        = 1'b0;
      sti_op        = 1'b0;
      ldb_op        = 1'b0;
      stb_op        = 1'b0;
      addr          = 16'h0000;
      store_data    = 16'h0000;
      dmem_rdata    = 16'h0000;
      dmem_resp     = 1'b0;
   endtask

   // Cache model: response after lat wait cycles (lat = 0 is zero-wait).
   task automatic run_access(input int lat, input logic [15:0] rd);
      for (int i = 0; i <= lat; i++) begin
         dmem_resp  = (i == lat);
         dmem_rdata = (i == lat) ? rd : 16'h0000;
         tick();
      end
      dmem_resp  = 1'b0;
      dmem_rdata = 16'h0000;
   endtask

   task automatic push_exp(input logic [15:0] a, input logic rd, input logic wr,
                           input logic [1:0] be, input logic [15:0] wd, input logic st,
                           input logic cl, input logic [15:0] ld);
      exp_t e;
      e.addr = a; e.rd = rd; e.wr = wr; e.be = be; e.wdata = wd;
      e.stall = st; e.chk_load = cl; e.load = ld;
      exp_q.push_back(e);
   endtask

   // Issue one instruction; the reference model derives every expected
   // cache access from the instruction semantics and pushes it up front.
   task automatic issue(input int kind, input logic [15:0] a, input logic [15:0] sd,
                        input int lat1, input logic [15:0] rd1,
                        input int lat2, input logic [15:0] rd2, input logic spurious);
      logic        is_byte;
      logic        is_ind;
      logic        is_load;
      logic        is_store;
      int          a0;
      logic [15:0] first_addr;
      logic [15:0] ptr;
      logic [15:0] exp_load;
      logic [15:0] exp_wd;
      logic [1:0]  exp_be;

      req_valid     = 1'b1;
      dcache_enable = (kind != K_NOP);
      dcacheR       = (kind == K_LDR) || (kind == K_LDB) || (kind == K_LDI) || (kind == K_TRAP);
      dcacheW       = (kind == K_STR) || (kind == K_STB) || (kind == K_STI);
      ldi_op        = (kind == K_LDI);
      sti_op        = (kind == K_STI);
      ldb_op        = (kind == K_LDB);
      stb_op        = (kind == K_STB);
      addr          = a;
      store_data    = sd;

      if (kind == K_NOP) begin
         dmem_resp = spurious;
         tick();
         dmem_resp = 1'b0;
         return;
      end

      is_byte    = (kind == K_LDB) || (kind == K_STB);
      is_ind     = (kind == K_LDI) || (kind == K_STI);
      is_load    = (kind == K_LDR) || (kind == K_LDB) || (kind == K_TRAP);
      is_store   = (kind == K_STR) || (kind == K_STB);
      a0         = int'(a[0]);
      first_addr = is_byte ? a : (a & 16'hFFFE);

      if (is_ind) begin
         ptr = rd1 & 16'hFFFE;
         push_exp(first_addr, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h0000);
         push_exp(ptr, kind == K_LDI, kind == K_STI, 2'b11, sd, 1'b0, kind == K_LDI, rd2);
         run_access(lat1, rd1);
         run_access(lat2, rd2);
      end else begin
         exp_be   = is_byte ? (2'b01 << a0) : 2'b11;
         exp_wd   = (kind == K_STB) ? ((sd & 16'h00FF) * 16'h0101) : sd;
         exp_load = (kind == K_LDB) ? ((rd1 >> (8 * a0)) & 16'h00FF) : rd1;
         push_exp(first_addr, is_load, is_store, exp_be, exp_wd, 1'b0, is_load, exp_load);
         run_access(lat1, rd1);
      end
   endtask

   // Monitor: pops the scoreboard whenever the cache completes an access.
   always @(negedge clk) begin
      exp_t r;
      if (!rst) begin
         if (req_valid && dcache_enable) begin
            if (dmem_resp && (dmem_read || dmem_write)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_access: got addr %h with empty scoreboard", dmem_address);
               end else begin
                  r = exp_q.pop_front();
                  chk("address", dmem_address, r.addr);
                  chk("read", {15'h0, dmem_read}, {15'h0, r.rd});
                  chk("write", {15'h0, dmem_write}, {15'h0, r.wr});
                  chk("byte_enable", {14'h0, dmem_byte_enable}, {14'h0, r.be});
                  chk("stall_on_resp", {15'h0, mem_stall}, {15'h0, r.stall});
                  if (r.wr) chk("wdata", dmem_wdata, r.wdata);
                  if (r.chk_load) chk("load_data", load_data, r.load);
               end
            end else begin
               chk("stall_wait", {15'h0, mem_stall}, 16'h0001);
            end
         end else begin
            chk("idle_strobes", {14'h0, dmem_read, dmem_write}, 16'h0000);
            chk("idle_be", {14'h0, dmem_byte_enable}, 16'h0000);
            chk("idle_stall", {15'h0, mem_stall}, 16'h0000);
         end
      end
   end

   initial begin
      int kind;
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_address", dmem_address, 16'h0000);
      chk("reset_wdata", dmem_wdata, 16'h0000);
      chk("reset_load", load_data, 16'h0000);
      chk("reset_strobes", {14'h0, dmem_read, dmem_write}, 16'h0000);
      tick();

      issue(K_LDR, 16'h3005, 16'h0000, 3, 16'hBEEF, 0, 16'h0, 1'b0);
      issue(K_LDB, 16'h2001, 16'h0000, 1, 16'hA57C, 0, 16'h0, 1'b0);
      issue(K_LDB, 16'h2000, 16'h0000, 0, 16'hA57C, 0, 16'h0, 1'b0);
      issue(K_STB, 16'h4000, 16'h1234, 2, 16'h0000, 0, 16'h0, 1'b0);
      issue(K_LDI, 16'h1000, 16'h0000, 1, 16'h5003, 1, 16'h0042, 1'b0);
      issue(K_STI, 16'h2222, 16'hCAFE, 0, 16'h6001, 0, 16'h0000, 1'b0);
      idle_inputs();
      dmem_resp = 1'b1;
      tick();
      dmem_resp = 1'b0;
      issue(K_STR, 16'h0101, 16'h9876, 0, 16'h0000, 0, 16'h0, 1'b0);
      issue(K_TRAP, 16'h0046, 16'h0000, 2, 16'h1234, 0, 16'h0, 1'b0);

      // Reset while the indirect second access is outstanding.
      req_valid = 1'b1; dcache_enable = 1'b1; dcacheR = 1'b1; ldi_op = 1'b1;
      addr = 16'h1000;
      push_exp(16'h1000, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b0, 16'h0000);
      run_access(0, 16'h7777);
      chk("second_addr_before_rst", dmem_address, 16'h7776);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("after_rst_strobes", {14'h0, dmem_read, dmem_write}, 16'h0000);
      chk("after_rst_stall", {15'h0, mem_stall}, 16'h0000);
      tick();
      issue(K_LDI, 16'h0FF0, 16'h0000, 1, 16'h00A1, 0, 16'h5A5A, 1'b0);

      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 7));
         issue(kind, 16'($urandom), 16'($urandom),
               int'($urandom_range(0, 3)), 16'($urandom),
               int'($urandom_range(0, 3)), 16'($urandom),
               1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            idle_inputs();
            dmem_resp = 1'($urandom_range(0, 1));
            tick();
            dmem_resp = 1'b0;
         end
      end

      idle_inputs();
      tick();
      tick();
      chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
